// File: rtl/aes_serial_loader_if.sv
// Bundle between the SPI-style serial master, the loader and the AES core.
// Carries both chip selects, the shared MOSI, both MISO echoes and the block/key valid/ready pair.
// Master drives selects, MOSI and out_ready; the loader drives everything else.
interface aes_serial_loader_if #(
  parameter int NK    = 6,
  parameter int BLK_W = 128
);
  localparam int KEY_W = 32 * NK;

  logic             cs_data_n;
  logic             cs_key_n;
  logic             mosi;
  logic             miso_data;
  logic             miso_key;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] out_block;
  logic [KEY_W-1:0] out_key;
  logic             frame_err;
  logic             busy;

  modport master (
    output cs_data_n, cs_key_n, mosi, out_ready,
    input  miso_data, miso_key, out_valid, out_block, out_key, frame_err, busy
  );

  modport slave (
    input  cs_data_n, cs_key_n, mosi, out_ready,
    output miso_data, miso_key, out_valid, out_block, out_key, frame_err, busy
  );
endinterface

// File: rtl/aes_serial_loader.sv
// Purpose: deserialises a block frame and a key frame (MSB first) and presents the pair to the AES core.
// Latency: out_valid rises one clock after the frame-end edge that completes the block/key pair.
// Backpressure: out_valid holds until out_ready; frames arriving while busy are ignored and flagged.
module aes_serial_loader #(
  parameter int NK       = 6,
  parameter int BLK_W    = 128,
  parameter bit KEEP_KEY = 1'b1
) (
  input logic           clk,
  input logic           rst,
  aes_serial_loader_if.slave bus
);
  localparam int KEY_W = 32 * NK;
  // Counters saturate one past full length so over-long frames stay distinguishable.
  localparam int DCW = $clog2(BLK_W + 2);
  localparam int KCW = $clog2(KEY_W + 2);
  localparam logic [DCW-1:0] D_FULL = DCW'(BLK_W);
  localparam logic [DCW-1:0] D_SAT  = DCW'(BLK_W + 1);
  localparam logic [KCW-1:0] K_FULL = KCW'(KEY_W);
  localparam logic [KCW-1:0] K_SAT  = KCW'(KEY_W + 1);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t           state;
  logic [BLK_W-1:0] sreg_data;
  logic [KEY_W-1:0] sreg_key;
  logic [DCW-1:0]   cnt_data;
  logic [KCW-1:0]   cnt_key;
  logic             viol_data;
  logic             viol_key;
  logic             cs_data_q;
  logic             cs_key_q;
  logic             loaded_data;
  logic             loaded_key;
  logic             out_valid;
  logic [BLK_W-1:0] out_block;
  logic [KEY_W-1:0] out_key;
  logic             frame_err;

  // Key shifts only when the data channel is not selected in the same cycle.
  logic key_sel;
  logic data_end, key_end, data_ok, key_ok;
  assign key_sel  = ~bus.cs_key_n & bus.cs_data_n;
  assign data_end = bus.cs_data_n & ~cs_data_q;
  assign key_end  = bus.cs_key_n & ~cs_key_q;
  assign data_ok  = data_end & (cnt_data == D_FULL) & ~viol_data;
  assign key_ok   = key_end & (cnt_key == K_FULL) & ~viol_key;

  // Data channel: shift while selected and idle, count bits, remember any bit seen while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_data <= '0;
      cnt_data  <= '0;
      viol_data <= 1'b0;
      cs_data_q <= 1'b1;
    end else begin
      cs_data_q <= bus.cs_data_n;
      if (!bus.cs_data_n) begin
        if (out_valid) begin
          viol_data <= 1'b1;
        end else begin
          sreg_data <= {sreg_data[BLK_W-2:0], bus.mosi};
          if (cnt_data != D_SAT) cnt_data <= cnt_data + DCW'(1);
        end
      end else if (!cs_data_q) begin
        cnt_data  <= '0;
        viol_data <= 1'b0;
      end
    end
  end

  // Key channel: same as data, but yields to the data channel when both selects are low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_key <= '0;
      cnt_key  <= '0;
      viol_key <= 1'b0;
      cs_key_q <= 1'b1;
    end else begin
      cs_key_q <= bus.cs_key_n;
      if (!bus.cs_key_n) begin
        if (out_valid) begin
          viol_key <= 1'b1;
        end else if (key_sel) begin
          sreg_key <= {sreg_key[KEY_W-2:0], bus.mosi};
          if (cnt_key != K_SAT) cnt_key <= cnt_key + KCW'(1);
        end
      end else if (!cs_key_q) begin
        cnt_key  <= '0;
        viol_key <= 1'b0;
      end
    end
  end

  // Handshake FSM: latch loaded flags on good frames, capture the pair, hold until accepted.
  // A capture clears loaded_data after any same-edge frame-end set, so a pair is never issued twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= COLLECT;
      out_valid   <= 1'b0;
      out_block   <= '0;
      out_key     <= '0;
      frame_err   <= 1'b0;
      loaded_data <= 1'b0;
      loaded_key  <= 1'b0;
    end else begin
      frame_err <= (data_end & ~data_ok) | (key_end & ~key_ok);
      if (data_ok) loaded_data <= 1'b1;
      if (key_ok)  loaded_key  <= 1'b1;
      case (state)
        COLLECT: begin
          if (loaded_data && loaded_key) begin
            out_block   <= sreg_data;
            out_key     <= sreg_key;
            out_valid   <= 1'b1;
            loaded_data <= 1'b0;
            if (!KEEP_KEY) loaded_key <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.miso_data = sreg_data[BLK_W-1];
  assign bus.miso_key  = sreg_key[KEY_W-1];
  assign bus.out_valid = out_valid;
  assign bus.busy      = out_valid;
  assign bus.out_block = out_block;
  assign bus.out_key   = out_key;
  assign bus.frame_err = frame_err;
endmodule

// File: doc/aes_serial_loader.md
Name: aes_serial_loader

Overview:
- Serial front-end for the parametrised AES core. Receives a 128-bit plaintext/ciphertext block and a 32*NK-bit key over an SPI-style single-bit link, with a separate chip-select per channel.
- Echoes the previous register contents on per-channel MISO lines.
- Presents a complete block/key pair to the core through a valid/ready handshake.
- Adds frame-length checking, backpressure and optional key retention for multi-block streams.

Parameters:
- NK, 6, key length in 32-bit words; legal values 4/6/8 (AES-128/192/256). Derived: KEY_W = 32*NK.
- BLK_W, 128, block width in bits; fixed at 128 for AES, parametrised for reuse.
- KEEP_KEY, 1, 1 = key stays loaded after a handshake, so data-only frames re-trigger output; 0 = every output needs a fresh key frame.

Ports:
- clk  in  1  clock; all sampling on posedge.
- rst  in  1  asynchronous, active-high reset.
- cs_data_n  in  1  data-channel chip select, active low.
- cs_key_n  in  1  key-channel chip select, active low.
- mosi  in  1  serial input, MSB first, shared by both channels.
- miso_data  out  1  data shift register bit [BLK_W-1].
- miso_key  out  1  key shift register bit [KEY_W-1].
- out_valid  out  1  block/key pair available.
- out_ready  in  1  core accepts the pair.
- out_block  out  BLK_W  captured block.
- out_key  out  KEY_W  captured key.
- frame_err  out  1  one-cycle pulse on a bad frame.
- busy  out  1  equals out_valid; frames arriving while high are rejected.

Behaviour:
- Reset (asynchronous, any state): all of the following go to 0:
  - shift registers, bit counters, loaded flags;
  - registered copies cs_data_q/cs_key_q (these reset to 1);
  - out_valid, out_block, out_key, frame_err.
  - miso_* therefore read 0.
  - A frame in progress is discarded; the master must restart it.
- Shifting:
  - On each posedge with cs_x_n=0 and busy=0: sreg_x <= {sreg_x[W-2:0], mosi}; cnt_x increments, saturating at W+1.
  - miso_x = sreg_x[W-1], combinational from the register. The master therefore reads back the prior contents MSB first.
  - Priority: if both selects are low in the same cycle, only the data channel shifts; the key channel holds and does not count.
- Frame end: detected at the posedge where cs_x_n=1 and cs_x_q=0.
  - cnt_x==W and no busy violation during the frame: loaded_x <= 1.
  - Otherwise: frame_err pulses for 1 cycle, and loaded_x keeps its previous value.
  - In both cases cnt_x <= 0.
  - A frame with cs low while busy=1 ignores its bits and flags frame_err at its end. A sticky per-frame violation bit is cleared at frame end.
- Handshake FSM, two states:
  - COLLECT (out_valid=0): at the posedge where loaded_data & loaded_key are both already 1:
    - out_block <= sreg_data; out_key <= sreg_key; out_valid <= 1; loaded_data <= 0;
    - loaded_key <= 0 only if KEEP_KEY=0;
    - go to HOLD.
    - Latency: out_valid rises exactly 1 cycle after the completing frame-end edge.
  - HOLD (out_valid=1): out_block/out_key stable. At the posedge with out_ready=1: out_valid <= 0, go to COLLECT.
    - out_ready is ignored in COLLECT.
- Simultaneous frame end and HOLD exit: frame ends still counted as rejected if any bit arrived while busy.
- Key replacement under KEEP_KEY=1: a new valid key frame overwrites sreg_key. A bad key frame leaves the old key loaded, but sreg_key content is partially shifted. The master must resend the key after frame_err on the key channel.
- Zero-length frame (cs pulse with no clocks low): cnt=0≠W → frame_err.

Test Plan:
- Reset, then data frame 00112233445566778899aabbccddeeff (128 clocks) and key frame 000102030405060708090a0b0c0d0e0f1011121314151617 (NK=6), out_ready=1 → out_valid for 1 cycle, 1 cycle after key frame end, with exact values; miso_data echoes 128 zeros.
- Same frames with out_ready=0 for 20 cycles → out_valid/busy held, outputs stable. A data frame sent during HOLD → frame_err pulse, out_block unchanged.
- Data frame of 127 bits, then 129 bits → frame_err each time, no out_valid. A correct 128-bit frame then works.
- KEEP_KEY=1: key once, then data blocks A and B → two out_valid events, both with the same out_key. With KEEP_KEY=0, block B produces no out_valid until a key is resent.
- Second data frame → miso_data streams the first block 00112233... MSB first.
- Assert rst at bit 60 of the key frame → all outputs 0 immediately. A full retransmission then yields correct out_valid. Repeat with NK=4 and NK=8 FIPS-197 keys.
